rv_instr_encoder: RTL and testbench

Sequential RV32I instruction encoder and program loader. It accepts decoded instruction descriptors over a valid/ready handshake, encodes each one into a 32-bit RV32I word, and writes the words in order into instruction memory through a single write port. It emits the inverse of the core's decode: R-type ALU, I-type ALU, LW, SW, BEQ and BNE. It sits beside imem and is used by the testbench or boot path to build programs; a finish request terminates the program with a halt word.

---
 rtl/rv_instr_encoder.sv | 110 +++++++++++
 tb/tb_rv_instr_encoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: encodes RV32I descriptors into words and writes them in order
// into imem; a finish request closes the program with a halt word.
module rv_instr_encoder #(
  parameter int DEPTH = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [3:0]        in_alu,
  input  logic              in_bne,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              finish,
  input  logic              start,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [1:0] {IDLE, WRITE, HALT, DONE} state_t;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  state_t state;
  logic [ADDR_W-1:0] idx;
  logic [2:0] f3;
  logic [6:0] f7;
  logic i_ok, imm_ok, legal;
  logic [31:0] enc, slot_addr;
  // the top slot stays reserved so a halt word always fits
  assign in_ready = state == IDLE && {1'b0, idx} < LAST;
  assign imem_we = state == WRITE || state == HALT;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign slot_addr = BASE_ADDR + (32'(idx) << 2);
  always_comb begin
    case (in_alu)
      4'd2: f3 = 3'b111;
      4'd3: f3 = 3'b110;
      4'd4: f3 = 3'b100;
      4'd5: f3 = 3'b001;
      4'd6, 4'd7: f3 = 3'b101;
      4'd8: f3 = 3'b010;
      default: f3 = 3'b000;
    endcase
    f7 = (in_alu == 4'd1 || in_alu == 4'd7) ? 7'h20 : 7'h00;
    i_ok = in_alu inside {4'd0, 4'd2, 4'd3, 4'd4, 4'd8};
    imm_ok = in_imm[12] == in_imm[11];
    case (in_kind)
      3'd0: begin enc = {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011}; legal = in_alu <= 4'd8; end
      3'd1: begin enc = {in_imm[11:0], in_rs1, f3, in_rd, 7'b0010011}; legal = i_ok && imm_ok; end
      3'd2: begin enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011}; legal = imm_ok; end
      3'd3: begin enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011}; legal = imm_ok; end
      3'd4: begin
        enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 2'b00, in_bne, in_imm[4:1], in_imm[11], 7'b1100011};
        legal = !in_imm[0];
      end
      default: begin enc = '0; legal = 1'b0; end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      imem_addr <= BASE_ADDR;
      imem_wdata <= '0;
      error <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE:
          if (in_valid && in_ready) begin
            if (legal) begin
              imem_wdata <= enc;
              imem_addr <= slot_addr;
              state <= WRITE;
            end else error <= 1'b1;
          end else if (finish) begin
            imem_wdata <= 32'h0000_0063;
            imem_addr <= slot_addr;
            state <= HALT;
          end
        WRITE: begin
          idx <= idx + ADDR_W'(1);
          word_count <= word_count + (ADDR_W+1)'(1);
          state <= IDLE;
        end
        HALT: begin
          word_count <= word_count + (ADDR_W+1)'(1);
          state <= DONE;
        end
        DONE:
          if (start) begin
            idx <= '0;
            word_count <= '0;
            error <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_instr_encoder.sv
// tb_rv_instr_encoder: directed and randomized programs checked against an
// instruction-level model of the RV32I field layouts and the loader's slot bookkeeping.
module tb_rv_instr_encoder;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
  logic clk = 0, rst_n = 0, in_valid = 0, in_bne = 0, finish = 0, start = 0;
  logic [2:0] in_kind = 0;
  logic [3:0] in_alu = 0;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [12:0] in_imm = 0;
  logic in_ready, imem_we, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [2:0] word_count;
  int vectors = 0, errors = 0;
  int m_idx = 0, m_wc = 0;
  logic m_err = 0;
  logic [31:0] got;

  rv_instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_alu(in_alu), .in_bne(in_bne), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .finish(finish),
    .start(start), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // returns {legal, word}, built from the ISA's field positions with plain arithmetic
  function automatic logic [32:0] model(input logic [2:0] k, input logic [3:0] a, input logic b,
                                        input logic [4:0] rd, rs1, rs2, input logic [12:0] imm);
    int f3_tab[9] = '{0, 0, 7, 6, 4, 1, 5, 5, 2};
    int v = $signed(imm);
    int op = int'(a), d = int'(rd), s1 = int'(rs1), s2 = int'(rs2);
    int f3 = (op <= 8) ? f3_tab[op] : 0;
    bit fits = v >= -2048 && v <= 2047;
    bit legal;
    int w;
    case (k)
      0: begin legal = op <= 8; w = 'h33 + d * 128 + f3 * 4096 + s1 * 32768 + s2 * (1 << 20) + ((op == 1 || op == 7) ? 32'h4000_0000 : 0); end
      1: begin legal = fits && (op == 0 || op == 2 || op == 3 || op == 4 || op == 8); w = 'h13 + d * 128 + f3 * 4096 + s1 * 32768 + (v & 'hFFF) * (1 << 20); end
      2: begin legal = fits; w = 'h03 + d * 128 + 2 * 4096 + s1 * 32768 + (v & 'hFFF) * (1 << 20); end
      3: begin legal = fits; w = 'h23 + (v & 31) * 128 + 2 * 4096 + s1 * 32768 + s2 * (1 << 20) + ((v >> 5) & 127) * (1 << 25); end
      4: begin
        legal = v % 2 == 0;
        w = 'h63 + ((v >> 11) & 1) * 128 + ((v >> 1) & 15) * 256 + int'(b) * 4096 + s1 * 32768 + s2 * (1 << 20)
            + ((v >> 5) & 63) * (1 << 25) + ((v >> 12) & 1) * (1 << 31);
      end
      default: begin legal = 0; w = 0; end
    endcase
    return {legal, 32'(w)};
  endfunction

  task automatic apply(input logic [2:0] k, input logic [3:0] a, input logic b,
                       input logic [4:0] rd, rs1, rs2, input logic [12:0] imm, output logic [31:0] word);
    logic [32:0] e;
    e = model(k, a, b, rd, rs1, rs2, imm);
    in_valid = 1; in_kind = k; in_alu = a; in_bne = b; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_idle: got %b want 1 (idx %0d)", in_ready, m_idx); end
    @(posedge clk); #1;
    in_valid = 0;
    word = imem_wdata;
    if (e[32]) begin
      vectors++;
      if (imem_we !== 1'b1 || imem_addr !== BASE + 32'(m_idx * 4) || imem_wdata !== e[31:0] || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL write k=%0d alu=%0d imm=%h: we=%b addr=%h data=%h ready=%b busy=%b want we=1 addr=%h data=%h ready=0 busy=1",
                 k, a, imm, imem_we, imem_addr, imem_wdata, in_ready, busy, BASE + 32'(m_idx * 4), e[31:0]);
      end
      m_idx++; m_wc++;
      @(posedge clk); #1;
      vectors++;
      if (imem_we !== 1'b0 || word_count !== 3'(m_wc) || busy !== 1'b0 || in_ready !== (m_idx < DEPTH - 1)) begin
        errors++;
        $display("FAIL after_write: we=%b count=%0d busy=%b ready=%b want we=0 count=%0d busy=0 ready=%b",
                 imem_we, word_count, busy, in_ready, m_wc, m_idx < DEPTH - 1);
      end
    end else begin
      m_err = 1;
      vectors++;
      if (imem_we !== 1'b0 || error !== 1'b1 || busy !== 1'b0 || word_count !== 3'(m_wc)) begin
        errors++;
        $display("FAIL illegal k=%0d alu=%0d imm=%h: we=%b error=%b busy=%b count=%0d want we=0 error=1 busy=0 count=%0d",
                 k, a, imm, imem_we, error, busy, word_count, m_wc);
      end
    end
  endtask

  task automatic do_finish();
    finish = 1;
    @(posedge clk); #1;
    finish = 0;
    vectors++;
    if (imem_we !== 1'b1 || imem_addr !== BASE + 32'(m_idx * 4) || imem_wdata !== 32'h0000_0063) begin
      errors++;
      $display("FAIL halt_write: we=%b addr=%h data=%h want we=1 addr=%h data=00000063", imem_we, imem_addr, imem_wdata, BASE + 32'(m_idx * 4));
    end
    m_wc++;
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || imem_we !== 1'b0 || in_ready !== 1'b0 || word_count !== 3'(m_wc) || error !== m_err) begin
      errors++;
      $display("FAIL done_state: done=%b we=%b ready=%b count=%0d error=%b want done=1 we=0 ready=0 count=%0d error=%b",
               done, imem_we, in_ready, word_count, error, m_wc, m_err);
    end
  endtask

  task automatic do_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    m_idx = 0; m_wc = 0; m_err = 0;
    vectors++;
    if (done !== 1'b0 || word_count !== 3'd0 || error !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL restart: done=%b count=%0d error=%b ready=%b busy=%b want 0 0 0 1 0", done, word_count, error, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    vectors++;
    if (in_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== BASE || imem_wdata !== 32'd0 || busy !== 1'b0 ||
        done !== 1'b0 || error !== 1'b0 || word_count !== 3'd0) begin
      errors++;
      $display("FAIL reset: ready=%b we=%b addr=%h data=%h busy=%b done=%b error=%b count=%0d", in_ready, imem_we,
               imem_addr, imem_wdata, busy, done, error, word_count);
    end
  endtask

  task automatic test_rtype();
    apply(0, 0, 0, 3, 1, 2, 0, got);
    vectors++;
    if (got !== 32'h002081B3) begin errors++; $display("FAIL add_word: got %h want 002081B3", got); end
    apply(0, 1, 0, 5, 6, 7, 0, got);
    vectors++;
    if (got !== 32'h407302B3) begin errors++; $display("FAIL sub_word: got %h want 407302B3", got); end
    do_finish();
    do_start();
  endtask

  task automatic test_imm_mem();
    apply(1, 0, 0, 1, 0, 0, 13'h1FFF, got);
    vectors++;
    if (got !== 32'hFFF00093) begin errors++; $display("FAIL addi_word: got %h want FFF00093", got); end
    apply(2, 0, 0, 4, 2, 0, 13'd8, got);
    vectors++;
    if (got !== 32'h00812203) begin errors++; $display("FAIL lw_word: got %h want 00812203", got); end
    apply(3, 0, 0, 0, 2, 5, 13'd12, got);
    vectors++;
    if (got !== 32'h00512623) begin errors++; $display("FAIL sw_word: got %h want 00512623", got); end
    do_finish();
    do_start();
  endtask

  task automatic test_branch();
    apply(4, 0, 0, 0, 1, 2, -13'sd8, got);
    vectors++;
    if (got !== 32'hFE208CE3) begin errors++; $display("FAIL beq_word: got %h want FE208CE3", got); end
    apply(4, 0, 1, 0, 1, 2, -13'sd8, got);
    vectors++;
    if (got !== 32'hFE209CE3) begin errors++; $display("FAIL bne_word: got %h want FE209CE3", got); end
    apply(4, 0, 0, 0, 1, 2, 13'd3, got);
    apply(0, 2, 0, 9, 10, 11, 0, got);
    do_finish();
    do_start();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH - 1; i++) apply(0, 4'(i), 0, 5'(i + 1), 2, 3, 0, got);
    in_valid = 1; in_kind = 0; in_alu = 0;
    repeat (2) begin
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b0 || imem_we !== 1'b0 || busy !== 1'b0 || word_count !== 3'(m_wc)) begin
        errors++;
        $display("FAIL full_ignore: ready=%b we=%b busy=%b count=%0d want 0 0 0 %0d", in_ready, imem_we, busy, word_count, m_wc);
      end
    end
    in_valid = 0;
    do_finish();
    vectors++;
    if (word_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", word_count); end
    in_valid = 1; finish = 1;
    repeat (2) begin
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b1 || imem_we !== 1'b0 || word_count !== 3'd4) begin
        errors++;
        $display("FAIL done_ignore: done=%b we=%b count=%0d want 1 0 4", done, imem_we, word_count);
      end
    end
    in_valid = 0; finish = 0;
    do_start();
  endtask

  task automatic test_back_to_back();
    logic [32:0] e;
    e = model(2, 0, 0, 7, 8, 0, 13'd20);
    in_valid = 1; in_kind = 2; in_rd = 7; in_rs1 = 8; in_imm = 13'd20; finish = 1;
    @(posedge clk); #1;
    in_valid = 0;
    vectors++;
    if (imem_we !== 1'b1 || imem_wdata !== e[31:0] || imem_addr !== BASE) begin
      errors++;
      $display("FAIL race_desc: we=%b data=%h addr=%h want we=1 data=%h addr=%h", imem_we, imem_wdata, imem_addr, e[31:0], BASE);
    end
    m_idx = 1; m_wc = 1;
    @(posedge clk); #1;
    vectors++;
    if (imem_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL race_idle: we=%b busy=%b want 0 0", imem_we, busy); end
    do_finish();
    do_start();
    apply(0, 3, 0, 1, 2, 3, 0, got);
    do_finish();
    do_start();
  endtask

  task automatic test_reset_mid_write();
    in_valid = 1; in_kind = 0; in_alu = 2; in_rd = 4; in_rs1 = 5; in_rs2 = 6;
    @(posedge clk); #1;
    in_valid = 0;
    vectors++;
    if (imem_we !== 1'b1) begin errors++; $display("FAIL mid_write_we: got %b want 1", imem_we); end
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    m_idx = 0; m_wc = 0; m_err = 0;
    vectors++;
    if (imem_we !== 1'b0 || imem_addr !== BASE || imem_wdata !== 32'd0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || error !== 1'b0 || word_count !== 3'd0) begin
      errors++;
      $display("FAIL mid_write_reset: we=%b addr=%h data=%h ready=%b busy=%b done=%b error=%b count=%0d",
               imem_we, imem_addr, imem_wdata, in_ready, busy, done, error, word_count);
    end
    apply(0, 0, 0, 1, 1, 1, 0, got);
    do_finish();
    do_start();
  endtask

  task automatic test_random();
    logic [12:0] imm;
    logic [2:0] k;
    for (int p = 0; p < 60; p++) begin
      int n = $urandom_range(0, 5);
      for (int j = 0; j < n && m_idx < DEPTH - 1; j++) begin
        k = 3'($urandom_range(0, 5));
        imm = $urandom_range(0, 1) ? 13'($urandom_range(0, 4095)) - 13'd2048 : 13'($urandom);
        if (k == 4 && $urandom_range(0, 3) != 0) imm[0] = 1'b0;
        apply(k, 4'($urandom_range(0, 10)), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm, got);
      end
      do_finish();
      do_start();
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_imm_mem();
    test_branch();
    test_full();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
